// File: rtl/box_scheduler_pkg.sv
// Shared types for the box_master write-engine scheduler.
package box_scheduler_pkg;

    // Slot descriptor produced by a special-memory bank and consumed by box_master.
    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  bank;
    } spec_slot;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } box_sched_state_e;

endpackage

// File: rtl/box_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last+1, modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt_onehot,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    // Walk candidates from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        int pos;
        pos        = 0;
        gnt_idx    = '0;
        any        = 1'b0;
        gnt_onehot = '0;
        for (int k = N; k >= 1; k--) begin
            pos = int'(last) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (req[pos[IW-1:0]]) begin
                gnt_idx = pos[IW-1:0];
                any     = 1'b1;
            end
        end
        if (any) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/box_scheduler.sv
// Round-robin scheduler sharing one box_master write engine between NUM_REQ slot producers.
// A slot is captured on accept and held stable until the burst handshake sequence completes.
module box_scheduler
    import box_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  spec_slot [NUM_REQ-1:0]     req_slot,
    output logic [NUM_REQ-1:0]         req_ready,
    output spec_slot                   out_slot,
    output logic                       tran_valid,
    input  logic                       tran_ready,
    output logic                       ready_fall,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [15:0]                done_cnt,
    output logic                       err_timeout
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);

    box_sched_state_e  state;
    spec_slot          hold_slot;
    logic [ID_W-1:0]   last_grant;
    logic [WD_W-1:0]   wd_cnt;

    logic [NUM_REQ-1:0] arb_onehot;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic               accept;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .last      (last_grant),
        .gnt_onehot(arb_onehot),
        .gnt_idx   (arb_idx),
        .any       (arb_any)
    );

    // Accept strobe only while idle; depends on state and req_valid alone.
    assign accept    = (state == IDLE) && arb_any;
    assign req_ready = (state == IDLE) ? arb_onehot : '0;
    assign out_slot  = hold_slot;

    // Main sequencing FSM: capture slot, present tran_valid, pulse ready_fall, wait for box completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tran_valid <= 1'b0;
            ready_fall <= 1'b0;
            busy       <= 1'b0;
            hold_slot  <= '0;
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            done_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        hold_slot  <= req_slot[arb_idx];
                        grant_id   <= arb_idx;
                        last_grant <= arb_idx;
                        tran_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (tran_valid && tran_ready) begin
                        tran_valid <= 1'b0;
                        ready_fall <= 1'b1;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    ready_fall <= 1'b0;
                    // tran_ready seen during the ready_fall cycle is stale; ignore it.
                    if (tran_ready && !ready_fall) begin
                        done_cnt <= done_cnt + 16'd1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Burst watchdog: saturating counter per burst, sticky flag; never aborts the burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else if (accept) begin
            wd_cnt <= '0;
        end else if (state != IDLE) begin
            if (wd_cnt == WD_LIMIT) begin
                err_timeout <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_box_scheduler.sv
// Directed self-checking bench for box_scheduler with a small box_master handshake model.
module tb_box_scheduler;
    import box_scheduler_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     req_valid;
    spec_slot [3:0] req_slot;
    logic [3:0]     req_ready;
    spec_slot       out_slot;
    logic           tran_valid;
    logic           tran_ready;
    logic           ready_fall;
    logic [1:0]     grant_id;
    logic           busy;
    logic [15:0]    done_cnt;
    logic           err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    int box_delay     = 1;
    int box_cnt       = 0;
    bit box_force_low = 1'b0;

    box_scheduler #(
        .NUM_REQ    (4),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_slot   (req_slot),
        .req_ready  (req_ready),
        .out_slot   (out_slot),
        .tran_valid (tran_valid),
        .tran_ready (tran_ready),
        .ready_fall (ready_fall),
        .grant_id   (grant_id),
        .busy       (busy),
        .done_cnt   (done_cnt),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // box_master model: drops tran_ready after the handshake, raises it box_delay cycles later.
    initial begin
        tran_ready = 1'b1;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                tran_ready = 1'b1;
                box_cnt    = 0;
            end else if (box_force_low) begin
                tran_ready = 1'b0;
            end else if (ready_fall) begin
                tran_ready = 1'b0;
                box_cnt    = box_delay;
            end else if (box_cnt > 0) begin
                box_cnt--;
                if (box_cnt == 0) tran_ready = 1'b1;
            end else begin
                tran_ready = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    function automatic spec_slot mk_slot(input int seed);
        spec_slot s;
        s.addr = 32'(seed) * 32'h0001_9E37 + 32'hA000_0000;
        s.len  = 8'(seed + 3);
        s.bank = 4'(seed);
        return s;
    endfunction

    task automatic do_reset();
        req_valid     = '0;
        box_force_low = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while (busy !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", name, busy, w);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) req_slot[i] = mk_slot(i + 1);
        do_reset();
        n_checks++; if (tran_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tran_valid: got %b exp 0", tran_valid); end
        n_checks++; if (ready_fall !== 1'b0) begin n_fail++; $display("FAIL rst_ready_fall: got %b exp 0", ready_fall); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant_id: got %0d exp 0", grant_id); end
        n_checks++; if (done_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_done_cnt: got %0d exp 0", done_cnt); end
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_err_timeout: got %b exp 0", err_timeout); end
        n_checks++; if (out_slot !== spec_slot'(0)) begin n_fail++; $display("FAIL rst_out_slot: got %h exp 0", out_slot); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b exp 0000", req_ready); end
    endtask

    task automatic test_single();
        spec_slot sa;
        sa = mk_slot(32'h1111);
        box_delay = 5;
        req_slot[2] = sa;
        req_valid   = 4'b0100;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_req_ready: got %b exp 0100", req_ready); end
        @(negedge clk);
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_req_ready_drop: got %b exp 0000", req_ready); end
        req_valid = '0;
        n_checks++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL single_grant_id: got %0d exp 2", grant_id); end
        n_checks++; if (tran_valid !== 1'b1) begin n_fail++; $display("FAIL single_tran_valid: got %b exp 1", tran_valid); end
        n_checks++; if (out_slot !== sa) begin n_fail++; $display("FAIL single_out_slot: got %h exp %h", out_slot, sa); end
        @(negedge clk);
        n_checks++; if (tran_valid !== 1'b0) begin n_fail++; $display("FAIL single_tran_valid_low: got %b exp 0", tran_valid); end
        n_checks++; if (ready_fall !== 1'b1) begin n_fail++; $display("FAIL single_ready_fall: got %b exp 1", ready_fall); end
        @(negedge clk);
        n_checks++; if (ready_fall !== 1'b0) begin n_fail++; $display("FAIL single_ready_fall_pulse: got %b exp 0", ready_fall); end
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || done_cnt !== 16'd0) begin n_fail++; $display("FAIL single_still_busy: busy=%b done=%0d exp busy=1 done=0", busy, done_cnt); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_back_idle: got busy=%b exp 0", busy); end
        n_checks++; if (done_cnt !== 16'd1) begin n_fail++; $display("FAIL single_done_cnt: got %0d exp 1", done_cnt); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_rr;
        do_reset();
        box_delay = 2;
        for (int i = 0; i < 4; i++) req_slot[i] = mk_slot(40 + i);
        req_valid = 4'b1111;
        #1;
        for (int b = 0; b < 8; b++) begin
            wait_idle("fair");
            exp_rr = 4'b0001 << (b % 4);
            n_checks++; if (done_cnt !== 16'(b)) begin n_fail++; $display("FAIL fair_done_cnt_%0d: got %0d exp %0d", b, done_cnt, b); end
            n_checks++; if (req_ready !== exp_rr) begin n_fail++; $display("FAIL fair_req_ready_%0d: got %b exp %b", b, req_ready, exp_rr); end
            @(negedge clk);
            n_checks++; if (grant_id !== 2'(b % 4)) begin n_fail++; $display("FAIL fair_grant_%0d: got %0d exp %0d", b, grant_id, b % 4); end
            n_checks++; if (out_slot !== mk_slot(40 + (b % 4))) begin n_fail++; $display("FAIL fair_slot_%0d: got %h exp %h", b, out_slot, mk_slot(40 + (b % 4))); end
        end
        wait_idle("fair_end");
        req_valid = '0;
        n_checks++; if (done_cnt !== 16'd8) begin n_fail++; $display("FAIL fair_done_total: got %0d exp 8", done_cnt); end
    endtask

    task automatic test_box_busy();
        spec_slot sc;
        int w;
        sc = mk_slot(77);
        req_slot[0]   = sc;
        box_force_low = 1'b1;
        req_valid     = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (tran_valid !== 1'b1) begin n_fail++; $display("FAIL busy_tran_valid_%0d: got %b exp 1", i, tran_valid); end
            n_checks++; if (ready_fall !== 1'b0) begin n_fail++; $display("FAIL busy_ready_fall_%0d: got %b exp 0", i, ready_fall); end
            n_checks++; if (out_slot !== sc) begin n_fail++; $display("FAIL busy_out_slot_%0d: got %h exp %h", i, out_slot, sc); end
            req_slot[0] = mk_slot(100 + i);
            @(negedge clk);
        end
        box_force_low = 1'b0;
        w = 0;
        while (ready_fall !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_checks++; if (ready_fall !== 1'b1) begin n_fail++; $display("FAIL busy_handshake: ready_fall=%b exp 1 within 20 cycles", ready_fall); end
        n_checks++; if (tran_valid !== 1'b0) begin n_fail++; $display("FAIL busy_tran_valid_after: got %b exp 0", tran_valid); end
        n_checks++; if (out_slot !== sc) begin n_fail++; $display("FAIL busy_out_slot_after: got %h exp %h", out_slot, sc); end
        wait_idle("busy");
        n_checks++; if (done_cnt !== 16'd9) begin n_fail++; $display("FAIL busy_done_cnt: got %0d exp 9", done_cnt); end
    endtask

    task automatic test_slot_stability();
        spec_slot sd;
        int w;
        sd = mk_slot(55);
        box_delay   = 6;
        req_slot[1] = sd;
        req_valid   = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL stab_grant_id: got %0d exp 1", grant_id); end
        w = 0;
        while (busy === 1'b1 && w < 30) begin
            req_slot[1] = mk_slot(200 + w);
            #1;
            n_checks++; if (out_slot !== sd) begin n_fail++; $display("FAIL stab_out_slot_%0d: got %h exp %h", w, out_slot, sd); end
            @(negedge clk);
            w++;
        end
        wait_idle("stab");
        repeat (2) @(negedge clk);
        n_checks++; if (out_slot !== sd) begin n_fail++; $display("FAIL stab_out_slot_idle: got %h exp %h", out_slot, sd); end
    endtask

    task automatic test_watchdog();
        do_reset();
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_initial: got %b exp 0", err_timeout); end
        box_delay = 30;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        repeat (15) @(negedge clk);
        n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_early: got %b exp 0 at cycle 15", err_timeout); end
        @(negedge clk);
        n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_rise: got %b exp 1 at cycle 16", err_timeout); end
        repeat (4) @(negedge clk);
        n_checks++; if (err_timeout !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL wd_hold: err=%b busy=%b exp 1 1", err_timeout, busy); end
        n_checks++; if (tran_valid !== 1'b0 || ready_fall !== 1'b0) begin n_fail++; $display("FAIL wd_wait_done: tv=%b rf=%b exp 0 0", tran_valid, ready_fall); end
        wait_idle("wd");
        n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_sticky: got %b exp 1", err_timeout); end
        n_checks++; if (done_cnt !== 16'd1) begin n_fail++; $display("FAIL wd_done_cnt: got %0d exp 1", done_cnt); end
    endtask

    task automatic test_reset_mid_burst();
        box_delay   = 8;
        req_slot[2] = mk_slot(99);
        req_valid   = 4'b0100;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (ready_fall !== 1'b1 || grant_id !== 2'd2) begin n_fail++; $display("FAIL mid_pre: rf=%b gid=%0d exp 1 2", ready_fall, grant_id); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (ready_fall !== 1'b0) begin n_fail++; $display("FAIL mid_ready_fall: got %b exp 0", ready_fall); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b exp 0", busy); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_grant_id: got %0d exp 0", grant_id); end
        n_checks++; if (out_slot !== spec_slot'(0)) begin n_fail++; $display("FAIL mid_out_slot: got %h exp 0", out_slot); end
        n_checks++; if (done_cnt !== 16'd0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL mid_counters: done=%0d err=%b exp 0 0", done_cnt, err_timeout); end
        n_checks++; if (tran_valid !== 1'b0) begin n_fail++; $display("FAIL mid_tran_valid: got %b exp 0", tran_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_valid = 4'b1010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_req_ready: got %b exp 0010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL mid_grant_after: got %0d exp 1", grant_id); end
        wait_idle("mid");
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_slot  = '0;
        test_reset();
        test_single();
        test_fairness();
        test_box_busy();
        test_slot_stability();
        test_watchdog();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
